// File: rtl/mac_result_packer.sv
// Requantizes the MAC engine's signed result stream (round, shift, saturate) and
// packs PACK lanes per output word, counting results against a per-job total.
module mac_result_packer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int PACK      = 4,
    parameter int CNT_LEN   = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [4:0]                    shift_i,
    input  logic [$clog2(CNT_LEN):0]      nb_res_i,
    input  logic [IN_WIDTH-1:0]           in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [OUT_WIDTH*PACK-1:0]     out_data_o,
    output logic [PACK-1:0]               out_strb_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(CNT_LEN):0]      cnt_o
);

    localparam int CNT_W  = $clog2(CNT_LEN) + 1;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WORD_W = OUT_WIDTH * PACK;

    localparam logic signed [IN_WIDTH:0] ROUND_ONE = (IN_WIDTH+1)'(1);
    localparam logic signed [IN_WIDTH:0] SAT_MAX   = (IN_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN   = (IN_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e              state_q,     state_d;
    logic [4:0]          shift_q,     shift_d;
    logic [CNT_W-1:0]    nb_res_q,    nb_res_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [LANE_W-1:0]   lane_idx_q,  lane_idx_d;
    logic [WORD_W-1:0]   buf_q,       buf_d;
    logic [WORD_W-1:0]   out_data_q,  out_data_d;
    logic [PACK-1:0]     out_strb_q,  out_strb_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    // Requantization datapath; one extra bit keeps the rounding add from overflowing.
    logic signed [IN_WIDTH:0]  in_ext;
    logic signed [IN_WIDTH:0]  rnd_sum;
    logic signed [IN_WIDTH:0]  shifted;
    logic [OUT_WIDTH-1:0]      quant;

    always_comb begin
        in_ext  = {in_data_i[IN_WIDTH-1], in_data_i};
        rnd_sum = in_ext + (ROUND_ONE <<< (shift_q - 5'd1));
        shifted = (shift_q == 5'd0) ? in_ext : (rnd_sum >>> shift_q);
        if (shifted > SAT_MAX) begin
            quant = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            quant = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            quant = shifted[OUT_WIDTH-1:0];
        end
    end

    // Handshake qualifiers; only an input that completes a word waits on the output register.
    logic               last_res;
    logic               word_done;
    logic               in_ready;
    logic               in_fire;
    logic               out_fire;
    logic [WORD_W-1:0]  word_fill;
    logic [PACK-1:0]    strb_fill;

    always_comb begin
        last_res  = (cnt_q + CNT_W'(1)) == nb_res_q;
        word_done = (lane_idx_q == LANE_W'(PACK-1)) || last_res;
        in_ready  = (state_q == RUN) && (!word_done || !out_valid_q || out_ready_i);
        in_fire   = in_valid_i && in_ready;
        out_fire  = out_valid_q && out_ready_i;

        word_fill = buf_q;
        word_fill[lane_idx_q*OUT_WIDTH +: OUT_WIDTH] = quant;
        for (int i = 0; i < PACK; i++) begin
            strb_fill[i] = (LANE_W'(i) <= lane_idx_q);
        end
    end

    // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        nb_res_d    = nb_res_q;
        cnt_d       = cnt_q;
        lane_idx_d  = lane_idx_q;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_valid_d = out_valid_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d    = shift_i;
                    nb_res_d   = nb_res_i;
                    cnt_d      = '0;
                    lane_idx_d = '0;
                    buf_d      = '0;
                    state_d    = (nb_res_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (word_done) begin
                        out_data_d  = word_fill;
                        out_strb_d  = strb_fill;
                        out_valid_d = 1'b1;
                        lane_idx_d  = '0;
                        buf_d       = '0;
                        if (last_res) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        buf_d      = word_fill;
                        lane_idx_d = lane_idx_q + LANE_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status is registered: busy covers the whole job, done follows the DONE state.
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);

        if (clear_i) begin
            state_d     = IDLE;
            shift_d     = '0;
            nb_res_d    = '0;
            cnt_d       = '0;
            lane_idx_d  = '0;
            buf_d       = '0;
            out_data_d  = '0;
            out_strb_d  = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            nb_res_q    <= '0;
            cnt_q       <= '0;
            lane_idx_q  <= '0;
            buf_q       <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            nb_res_q    <= nb_res_d;
            cnt_q       <= cnt_d;
            lane_idx_q  <= lane_idx_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_mac_result_packer.sv
// Directed bench for mac_result_packer: hand-computed packed words, strobes,
// backpressure behaviour, completion timing, empty jobs and soft clear.
module tb_mac_result_packer;

    localparam int CNT_W  = 11;
    localparam int WORD_W = 32;
    localparam int PACK   = 4;

    logic                clk_i;
    logic                rst_ni;
    logic                clear_i;
    logic                start_i;
    logic [4:0]          shift_i;
    logic [CNT_W-1:0]    nb_res_i;
    logic [31:0]         in_data_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [WORD_W-1:0]   out_data_o;
    logic [PACK-1:0]     out_strb_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                busy_o;
    logic                done_o;
    logic [CNT_W-1:0]    cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    logic [WORD_W-1:0] got_data[$];
    logic [PACK-1:0]   got_strb[$];
    logic [WORD_W-1:0] exp_data[$];
    logic [PACK-1:0]   exp_strb[$];

    int w_dummy;
    int w5, w6, w7, w8;

    mac_result_packer #(
        .IN_WIDTH (32),
        .OUT_WIDTH(8),
        .PACK     (4),
        .CNT_LEN  (1024)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .shift_i    (shift_i),
        .nb_res_i   (nb_res_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_strb_o (out_strb_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cnt_o      (cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change just after rising edges, so the falling edge sees what the next edge will sample.
    always @(negedge clk_i) begin
        if (out_valid_o && out_ready_i) begin
            got_data.push_back(out_data_o);
            got_strb.push_back(out_strb_o);
        end
        if (done_o) done_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start_job(input logic [4:0] sh, input logic [CNT_W-1:0] nb);
        start_i  = 1'b1;
        shift_i  = sh;
        nb_res_i = nb;
        step();
        start_i  = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, output int waits);
        in_valid_i = 1'b1;
        in_data_i  = d;
        waits      = 0;
        @(negedge clk_i);
        while (!in_ready_o && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        if (!in_ready_o) check("in_ready_timeout", in_ready_o, 1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_data_i  = '0;
    endtask

    task automatic wait_done(input string tag);
        logic prev_busy;
        bit   seen;
        seen      = 1'b0;
        prev_busy = busy_o;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                check({tag, "_busy_falls_with_done"}, {busy_o, prev_busy}, 2'b01);
            end
            prev_busy = busy_o;
        end
        check({tag, "_done_seen"}, seen, 1);
        step();
        check({tag, "_done_one_cycle"}, done_o, 0);
    endtask

    task automatic check_words(input string tag, input int exp_done);
        check({tag, "_nwords"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < got_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
                check($sformatf("%s_strb%0d", tag, i), got_strb[i], exp_strb[i]);
            end
        end
        check({tag, "_done_cnt"}, done_seen, exp_done);
        got_data.delete();
        got_strb.delete();
        exp_data.delete();
        exp_strb.delete();
        done_seen = 0;
    endtask

    task automatic run4(input string tag, input logic [4:0] sh,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [31:0] exp_word);
        int w;
        start_job(sh, 11'd4);
        push(d0, w);
        push(d1, w);
        push(d2, w);
        push(d3, w);
        wait_done(tag);
        exp_data.push_back(exp_word);
        exp_strb.push_back(4'b1111);
        check_words(tag, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        shift_i     = '0;
        nb_res_i    = '0;
        in_data_i   = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step(3);
        rst_ni = 1'b1;
        step();

        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data",  out_data_o,  0);
        check("rst_out_strb",  out_strb_o,  0);
        check("rst_busy",      busy_o,      0);
        check("rst_done",      done_o,      0);
        check("rst_cnt",       cnt_o,       0);
        check("rst_in_ready",  in_ready_o,  0);

        // Job 1: plain packing, output one cycle after the 4th handshake.
        start_job(5'd0, 11'd4);
        check("j1_busy_after_start", busy_o, 1);
        push(32'd1, w_dummy);
        push(32'd2, w_dummy);
        push(32'd3, w_dummy);
        push(32'd4, w_dummy);
        check("j1_out_valid", out_valid_o, 1);
        check("j1_out_data",  out_data_o,  32'h0403_0201);
        check("j1_out_strb",  out_strb_o,  4'b1111);
        wait_done("j1");
        check("j1_cnt", cnt_o, 4);
        check("j1_busy_idle", busy_o, 0);
        exp_data.push_back(32'h0403_0201);
        exp_strb.push_back(4'b1111);
        check_words("j1", 1);

        run4("rnd4", 5'd4, 32'd24, 32'd23, -32'sd24, -32'sd25, 32'hFEFF_0102);
        run4("sat",  5'd0, 32'd1000, -32'sd1000, 32'd127, -32'sd128, 32'h807F_807F);
        run4("rnd1", 5'd1, 32'd3, -32'sd3, 32'd1, -32'sd1, 32'h0001_FF02);
        run4("sh31", 5'd31, 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h3FFF_FFFF,
             32'h0001_FF01);

        // Partial last word.
        start_job(5'd0, 11'd6);
        for (int i = 1; i <= 6; i++) push(32'(i), w_dummy);
        wait_done("j6");
        check("j6_cnt", cnt_o, 6);
        exp_data.push_back(32'h0403_0201);
        exp_strb.push_back(4'b1111);
        exp_data.push_back(32'h0000_0605);
        exp_strb.push_back(4'b0011);
        check_words("j6", 1);

        // Empty job: straight to completion, no output.
        start_job(5'd0, 11'd0);
        check("nb0_busy_c1", busy_o, 1);
        check("nb0_done_c1", done_o, 0);
        step();
        check("nb0_done_c2", done_o, 1);
        check("nb0_busy_c2", busy_o, 0);
        check("nb0_valid",   out_valid_o, 0);
        step();
        check("nb0_done_c3", done_o, 0);
        check_words("nb0", 1);

        // Backpressure: output ready held low for 8 cycles while 8 results stream in.
        out_ready_i = 1'b0;
        start_job(5'd0, 11'd8);
        fork
            begin
                push(32'd1, w_dummy);
                push(32'd2, w_dummy);
                push(32'd3, w_dummy);
                push(32'd4, w_dummy);
                push(32'd5, w5);
                push(32'd6, w6);
                push(32'd7, w7);
                check("bp_lane_fill_no_stall", w5 + w6 + w7, 0);
                check("bp_held_valid", out_valid_o, 1);
                check("bp_held_data",  out_data_o,  32'h0403_0201);
                push(32'd8, w8);
                check("bp_last_stall_cycles", w8, 1);
            end
            begin
                repeat (8) @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
        join
        wait_done("bp");
        check("bp_cnt", cnt_o, 8);
        exp_data.push_back(32'h0403_0201);
        exp_strb.push_back(4'b1111);
        exp_data.push_back(32'h0807_0605);
        exp_strb.push_back(4'b1111);
        check_words("bp", 1);

        // Soft clear mid-job, then a fresh job must start from lane 0.
        start_job(5'd0, 11'd8);
        push(32'd5, w_dummy);
        push(32'd6, w_dummy);
        push(32'd7, w_dummy);
        check("clr_cnt_before", cnt_o, 3);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("clr_out_valid", out_valid_o, 0);
        check("clr_busy",      busy_o,      0);
        check("clr_cnt",       cnt_o,       0);
        check("clr_in_ready",  in_ready_o,  0);
        step(4);
        check_words("clr", 0);
        run4("post_clr", 5'd0, 32'd9, 32'd10, 32'd11, 32'd12, 32'h0C0B_0A09);

        step(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
